// File: rtl/nor_pkg.sv
// Shared constants and helpers for the NOR stage and its BIST sequencer.
package nor_pkg;
  localparam int NOR_WIDTH_DEFAULT = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // One extra bit so a fully failing sweep (2^(2w) errors) still fits.
  function automatic int err_cnt_width(input int w);
    return 2 * w + 1;
  endfunction
endpackage

// File: rtl/nor_bist_if.sv
// Operand/result bus and status signals between the BIST sequencer and its user.
interface nor_bist_if import nor_pkg::*; #(
  parameter int WIDTH = NOR_WIDTH_DEFAULT
) ();
  localparam int EW = err_cnt_width(WIDTH);

  logic             i_start;
  logic [WIDTH-1:0] i_nor;
  logic [WIDTH-1:0] o_op1;
  logic [WIDTH-1:0] o_op2;
  logic             o_busy;
  logic             o_done;
  logic             o_pass;
  logic [EW-1:0]    o_err_cnt;
  logic [WIDTH-1:0] o_first_op1;
  logic [WIDTH-1:0] o_first_op2;

  modport master (
    output i_start, i_nor,
    input  o_op1, o_op2, o_busy, o_done, o_pass, o_err_cnt, o_first_op1, o_first_op2
  );
  modport slave (
    input  i_start, i_nor,
    output o_op1, o_op2, o_busy, o_done, o_pass, o_err_cnt, o_first_op1, o_first_op2
  );
endinterface

// File: rtl/bitwise_nor.sv
// Parameterised bitwise NOR; used as the golden reference inside the BIST.
module bitwise_nor #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_y
);
  assign o_y = ~(i_a | i_b);
endmodule

// File: rtl/nor_bist.sv
// Exhaustive self-test sequencer for the NOR stage: one operand pair per clock,
// compared against a golden NOR, with error count and first failing pair.
module nor_bist import nor_pkg::*; #(
  parameter int WIDTH = NOR_WIDTH_DEFAULT
) (
  input  logic      i_clk,
  input  logic      i_rst,
  nor_bist_if.slave bus
);
  localparam int CW = 2 * WIDTH;
  localparam int EW = err_cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [EW-1:0] ERR_ONE = EW'(1);

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic [EW-1:0]    r_err_cnt;
  logic [WIDTH-1:0] r_first_op1;
  logic [WIDTH-1:0] r_first_op2;

  logic [WIDTH-1:0] w_op1;
  logic [WIDTH-1:0] w_op2;
  logic [WIDTH-1:0] w_exp;
  logic             w_mis;

  assign w_op1 = r_cnt[CW-1:WIDTH];
  assign w_op2 = r_cnt[WIDTH-1:0];

  bitwise_nor #(.WIDTH(WIDTH)) u_golden (
    .i_a (w_op1),
    .i_b (w_op2),
    .o_y (w_exp)
  );

  // Case inequality so an undriven or X result bit is flagged as a mismatch.
  assign w_mis = (bus.i_nor !== w_exp);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_err_cnt   <= '0;
      r_first_op1 <= '0;
      r_first_op2 <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.i_start) begin
            r_state     <= S_RUN;
            r_busy      <= 1'b1;
            r_cnt       <= '0;
            r_pass      <= 1'b0;
            r_err_cnt   <= '0;
            r_first_op1 <= '0;
            r_first_op2 <= '0;
          end
        end
        S_RUN: begin
          r_cnt <= r_cnt + CNT_ONE;
          if (w_mis) begin
            r_err_cnt <= r_err_cnt + ERR_ONE;
            if (r_err_cnt == '0) begin
              r_first_op1 <= w_op1;
              r_first_op2 <= w_op2;
            end
          end
          // The last pair may itself fail, so fold its result into pass.
          if (&r_cnt) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (r_err_cnt == '0) && !w_mis;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.o_op1       = w_op1;
  assign bus.o_op2       = w_op2;
  assign bus.o_busy      = r_busy;
  assign bus.o_done      = r_done;
  assign bus.o_pass      = r_pass;
  assign bus.o_err_cnt   = r_err_cnt;
  assign bus.o_first_op1 = r_first_op1;
  assign bus.o_first_op2 = r_first_op2;
endmodule

// File: tb/tb_nor_bist.sv
// Scoreboard bench for nor_bist: WIDTH=4 with fault-injecting NOR stage, plus WIDTH=2.
module tb_nor_bist;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   fmode = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  nor_bist_if #(.WIDTH(4)) if4 ();
  nor_bist_if #(.WIDTH(2)) if2 ();

  nor_bist #(.WIDTH(4)) dut4 (.i_clk(clk), .i_rst(rst), .bus(if4));
  nor_bist #(.WIDTH(2)) dut2 (.i_clk(clk), .i_rst(rst), .bus(if2));

  // NOR stage model: 0 = good, 1 = bit0 stuck-at-0, 2 = returns ~op1
  always_comb begin
    case (fmode)
      1:       if4.i_nor = ~(if4.o_op1 | if4.o_op2) & 4'b1110;
      2:       if4.i_nor = ~if4.o_op1;
      default: if4.i_nor = ~(if4.o_op1 | if4.o_op2);
    endcase
  end
  assign if2.i_nor = ~(if2.o_op1 | if2.o_op2);

  typedef struct {
    int err;
    int f1;
    int f2;
    bit pass;
  } exp_t;

  exp_t q4[$];
  exp_t q2[$];

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitors: track operand sequence during RUN and pop the scoreboard on o_done.
  int run4 = 0, nxt4 = 0, seqbad4 = 0;
  int run2 = 0, nxt2 = 0, seqbad2 = 0;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      run4 = 0; nxt4 = 0; seqbad4 = 0;
    end else begin
      if (if4.o_busy) begin
        if (int'({if4.o_op1, if4.o_op2}) != nxt4) seqbad4++;
        nxt4++; run4++;
      end
      if (if4.o_done) begin
        if (q4.size() == 0) chk("done4_unexpected", 1, 0);
        else begin
          e = q4.pop_front();
          chk("err_cnt4", if4.o_err_cnt, e.err);
          chk("pass4", if4.o_pass, e.pass);
          chk("first_op1_4", if4.o_first_op1, e.f1);
          chk("first_op2_4", if4.o_first_op2, e.f2);
          chk("run_len4", run4, 256);
          chk("op_seq4", seqbad4, 0);
          chk("busy_at_done4", if4.o_busy, 0);
          chk("ops_wrap4", {if4.o_op1, if4.o_op2}, 0);
        end
        run4 = 0; nxt4 = 0; seqbad4 = 0;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      run2 = 0; nxt2 = 0; seqbad2 = 0;
    end else begin
      if (if2.o_busy) begin
        if (int'({if2.o_op1, if2.o_op2}) != nxt2) seqbad2++;
        nxt2++; run2++;
      end
      if (if2.o_done) begin
        if (q2.size() == 0) chk("done2_unexpected", 1, 0);
        else begin
          e = q2.pop_front();
          chk("err_cnt2", if2.o_err_cnt, e.err);
          chk("pass2", if2.o_pass, e.pass);
          chk("run_len2", run2, 16);
          chk("op_seq2", seqbad2, 0);
        end
        run2 = 0; nxt2 = 0; seqbad2 = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_done4(output int n);
    n = 0;
    do begin tick(); n++; end while (!if4.o_done && n < 600);
    if (!if4.o_done) chk("timeout4", 1, 0);
  endtask

  task automatic sweep4(input int mode, input int err, input int f1, input int f2,
                        input bit toggle, input string nm);
    int n;
    fmode = mode;
    q4.push_back('{err, f1, f2, err == 0});
    if4.i_start = 1'b1;
    tick();
    if4.i_start = 1'b0;
    chk({nm, "_busy_start"}, if4.o_busy, 1);
    n = 0;
    do begin
      if (toggle) if4.i_start = n[0];
      tick(); n++;
    end while (!if4.o_done && n < 600);
    if4.i_start = 1'b0;
    if (!if4.o_done) chk({nm, "_timeout"}, 1, 0);
    chk({nm, "_done_lat"}, n, 256);
    tick();
    chk({nm, "_done_pulse"}, if4.o_done, 0);
    chk({nm, "_pass_held"}, if4.o_pass, err == 0);
  endtask

  task automatic check_zero4(input string nm);
    chk({nm, "_busy"}, if4.o_busy, 0);
    chk({nm, "_done"}, if4.o_done, 0);
    chk({nm, "_pass"}, if4.o_pass, 0);
    chk({nm, "_err"}, if4.o_err_cnt, 0);
    chk({nm, "_ops"}, {if4.o_op1, if4.o_op2}, 0);
    chk({nm, "_first"}, {if4.o_first_op1, if4.o_first_op2}, 0);
  endtask

  initial begin
    int n;
    if4.i_start = 1'b0;
    if2.i_start = 1'b0;
    rst = 1'b1;
    tick(); tick();
    check_zero4("reset");
    chk("reset2_busy", if2.o_busy, 0);
    chk("reset2_err", if2.o_err_cnt, 0);
    rst = 1'b0;
    tick();

    // 1-3: clean, stuck bit0, ~op1
    sweep4(0, 0,   0, 0, 1'b0, "clean");
    sweep4(1, 64,  0, 0, 1'b0, "stuck0");
    sweep4(2, 175, 0, 1, 1'b0, "notop1");

    // 4: reset mid-RUN, with start also high to show reset wins
    fmode = 1;
    q4.push_back('{0, 0, 0, 1'b0});
    if4.i_start = 1'b1;
    tick();
    if4.i_start = 1'b0;
    repeat (99) tick();
    chk("abort_running", if4.o_busy, 1);
    chk("abort_err_nonzero", if4.o_err_cnt > 0, 1);
    rst = 1'b1;
    if4.i_start = 1'b1;
    tick();
    q4.delete();
    check_zero4("abort");
    rst = 1'b0;
    if4.i_start = 1'b0;
    tick();
    chk("abort_idle", if4.o_busy, 0);
    sweep4(0, 0, 0, 0, 1'b0, "restart");

    // 5a: start toggling during RUN must not restart
    sweep4(0, 0, 0, 0, 1'b1, "toggle");

    // 5b: start held high gives back-to-back sweeps, DONE then IDLE between
    fmode = 0;
    q4.push_back('{0, 0, 0, 1'b1});
    q4.push_back('{0, 0, 0, 1'b1});
    if4.i_start = 1'b1;
    tick();
    wait_done4(n);
    chk("b2b_first_lat", n, 256);
    tick();
    chk("b2b_idle_busy", if4.o_busy, 0);
    chk("b2b_idle_done", if4.o_done, 0);
    tick();
    chk("b2b_restart_busy", if4.o_busy, 1);
    if4.i_start = 1'b0;
    wait_done4(n);
    chk("b2b_second_lat", n, 256);
    tick();

    // 6: WIDTH=2
    q2.push_back('{0, 0, 0, 1'b1});
    if2.i_start = 1'b1;
    tick();
    if2.i_start = 1'b0;
    n = 0;
    do begin tick(); n++; end while (!if2.o_done && n < 100);
    if (!if2.o_done) chk("timeout2", 1, 0);
    chk("w2_done_lat", n, 16);
    tick(); tick();

    chk("q4_drained", q4.size(), 0);
    chk("q2_drained", q2.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
